// File: rtl/scoreboard_forwarding_unit.sv
// scoreboard_forwarding_unit
// Tracks in-flight producers between EX and register-file commit and forwards
// their results to consumer source ports. Loads enter not-ready and become
// ready when their data returns at LOAD_STAGE; a consumer that hits a
// not-ready entry raises stall.
// Optional build macro: FWD_STATS_EN adds saturating forward/stall counters.
module scoreboard_forwarding_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      iss_valid,
  input  logic [4:0]                iss_rd,
  input  logic                      iss_we,
  input  logic                      iss_is_load,
  input  logic [XLEN-1:0]           iss_data,
  input  logic                      ld_valid,
  input  logic [XLEN-1:0]           ld_data,
  input  logic [NUM_SRC*5-1:0]      rs_addr,
  output logic [NUM_SRC-1:0]        fwd_hit,
  output logic [NUM_SRC*XLEN-1:0]   fwd_data,
  output logic                      stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]               stat_fwd_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  // Index 0 is entry 1 (youngest); index DEPTH-1 is the oldest entry.
  localparam int LS = LOAD_STAGE - 1;
  // Where a load update lands after a shift; only meaningful when the
  // load stage is not the last entry (otherwise the update leaves with it).
  localparam bit LD_SHIFT_KEEP = (LOAD_STAGE < DEPTH);
  localparam int LS_NEXT       = LD_SHIFT_KEEP ? LOAD_STAGE : DEPTH - 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];

  logic ld_take;
  assign ld_take = ld_valid & valid_q[LS] & ~ready_q[LS];

  // Next entry state: shift/capture when not held, load return applied
  // to the entry's current or shifted position.
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_d[k] = valid_q[k-1];
        ready_d[k] = ready_q[k-1];
        rd_d[k]    = rd_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      valid_d[0] = iss_valid & iss_we & ~flush & (iss_rd != 5'd0);
      rd_d[0]    = iss_rd;
      data_d[0]  = iss_data;
      ready_d[0] = ~iss_is_load;
      if (ld_take && LD_SHIFT_KEEP) begin
        data_d[LS_NEXT]  = ld_data;
        ready_d[LS_NEXT] = 1'b1;
      end
    end else if (ld_take) begin
      data_d[LS]  = ld_data;
      ready_d[LS] = 1'b1;
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  logic [4:0]      rs_cur;
  logic            found;
  logic            sel_ready;
  logic [XLEN-1:0] sel_data;

  // Per-port lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit   = '0;
    fwd_data  = '0;
    stall     = 1'b0;
    rs_cur    = '0;
    found     = 1'b0;
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_cur    = rs_addr[i*5 +: 5];
      found     = 1'b0;
      sel_ready = 1'b0;
      sel_data  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && (rs_cur != 5'd0) && (rd_q[k] == rs_cur)) begin
          found     = 1'b1;
          sel_ready = ready_q[k];
          sel_data  = data_q[k];
        end
      end
      if (found && sel_ready) begin
        fwd_hit[i]               = 1'b1;
        fwd_data[i*XLEN +: XLEN] = sel_data;
      end
      if (found && !sel_ready) begin
        stall = 1'b1;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stat_fwd_cnt_q, stat_fwd_cnt_d;
  logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

  // Saturating event counters.
  always_comb begin
    stat_fwd_cnt_d   = stat_fwd_cnt_q;
    stat_stall_cnt_d = stat_stall_cnt_q;
    if ((|fwd_hit) && !hold && (stat_fwd_cnt_q != 32'hFFFF_FFFF)) begin
      stat_fwd_cnt_d = stat_fwd_cnt_q + 32'd1;
    end
    if (stall && (stat_stall_cnt_q != 32'hFFFF_FFFF)) begin
      stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd_cnt_q   <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      stat_fwd_cnt_q   <= stat_fwd_cnt_d;
      stat_stall_cnt_q <= stat_stall_cnt_d;
    end
  end

  assign stat_fwd_cnt   = stat_fwd_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule

// File: doc/scoreboard_forwarding_unit.md
SCOREBOARD_FORWARDING_UNIT -- requirements
Module: scoreboard_forwarding_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the sole clock and rst is the reset, sampled on the rising edge of clk.
REQ-002 Parameter XLEN, default 32: width of register data.
REQ-003 Parameter NUM_SRC, default 2: number of consumer source-operand ports.
REQ-004 Parameter DEPTH, default 3: number of in-flight producer entries; legal range 2..8.
REQ-005 Parameter LOAD_STAGE, default 2: entry index (1..DEPTH) at which load data returns.
REQ-006 Ports SHALL be, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- hold  in  1  freezes the whole pipeline; no shift and no capture.
- flush  in  1  the issue this cycle is squashed.
- iss_valid  in  1  a producer leaves EX this cycle.
- iss_rd  in  5  producer destination register.
- iss_we  in  1  producer writes the register file.
- iss_is_load  in  1  producer data is not ready until load return.
- iss_data  in  XLEN  producer ALU result.
- ld_valid  in  1  load data returns for the entry at LOAD_STAGE.
- ld_data  in  XLEN  returned load data.
- rs_addr  in  NUM_SRC*5  consumer source addresses; port i occupies bits [5i+4:5i].
- fwd_hit  out  NUM_SRC  port i takes forwarded data.
- fwd_data  out  NUM_SRC*XLEN  forwarded value per port.
- stall  out  1  a consumer depends on an entry that is not ready.

Function
REQ-007 Each entry 1..DEPTH SHALL hold four fields: valid, rd, data, ready. Entry 1 is the youngest.
REQ-008 Shift rule, evaluated on each edge when hold=0:
- entry k+1 takes entry k;
- entry DEPTH is discarded, because its value is committed in the register file;
- entry 1 takes the issue.
REQ-009 Issue capture into entry 1:
- valid = iss_valid & iss_we & !flush & (iss_rd != 0);
- rd = iss_rd;
- data = iss_data;
- ready = !iss_is_load.
REQ-010 When hold=1, entries SHALL keep their position, and issue inputs SHALL be ignored.
REQ-011 ld_valid SHALL be honoured regardless of hold.
- If the entry at LOAD_STAGE is valid and not ready: it SHALL receive data=ld_data and ready=1.
- If hold=0, that update SHALL land in the entry's shifted position, LOAD_STAGE+1, or SHALL be discarded if LOAD_STAGE=DEPTH.
- Otherwise ld_valid SHALL be ignored.
REQ-012 Lookup per port i SHALL be combinational from registered state.
- Select the youngest valid entry with rd == rs_addr[i].
- rs_addr[i]=0 SHALL never match.
REQ-013 If the selected entry is ready: fwd_hit[i]=1 and fwd_data[i]=entry data.
REQ-014 If there is no match, or the selected entry is not ready: fwd_hit[i]=0 and fwd_data[i]=0.
REQ-015 stall=1 iff any port's selected entry is valid and not ready.
- An older ready entry SHALL NOT mask a younger pending one.
REQ-016 ld_data SHALL NOT be forwarded in the cycle it arrives; it is visible from the next cycle.
REQ-017 A pending load that passes LOAD_STAGE without ld_valid SHALL stay not-ready.
- The resulting stall SHALL persist until the entry exits DEPTH.
REQ-018 Latency: an issue captured at edge t SHALL be visible to lookup from cycle t+1 until it shifts out, or until a younger matching entry supersedes it.

Reset
REQ-019 On rst=1, all entries SHALL be cleared to valid=0, ready=0, rd=0 and data=0 at the next edge.
- rst SHALL override hold, flush, ld_valid and issue.
REQ-020 While state is reset, outputs SHALL read fwd_hit=0, fwd_data=0 and stall=0.
REQ-021 Reset asserted mid-load SHALL discard all pending entries, with no residual stall after release.

Configuration
REQ-022 Macro FWD_STATS_EN.
- When defined: the block SHALL add outputs stat_fwd_cnt (out, 32 bits) and stat_stall_cnt (out, 32 bits).
- stat_fwd_cnt SHALL increment once per cycle in which any fwd_hit=1 and hold=0.
- stat_stall_cnt SHALL increment once per cycle with stall=1.
- Both counters SHALL saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: these ports and the counter logic SHALL be absent.

Verification
REQ-023 Back-to-back ALU: issue rd=5, data=0x11 at edge 0; rs_addr[0]=5 in cycle 1 -> fwd_hit[0]=1, fwd_data[0]=0x11, stall=0.
REQ-024 Youngest wins: issue rd=7, data=0xA; then issue rd=7, data=0xB; query rs=7 -> fwd_data=0xB. After 3 further non-writing issues (DEPTH=3) -> fwd_hit=0.
REQ-025 Load-use: issue load rd=3; query rs=3 -> stall=1 until ld_valid with ld_data=0xDEAD at LOAD_STAGE. Next cycle -> fwd_hit=1, fwd_data=0xDEAD, stall=0.
REQ-026 Hold and x0 cases:
- hold=1 for 4 cycles with rd=9 ready at entry 1 -> fwd_data for rs=9 unchanged and entry not aged.
- An issue with rd=0, or flush=1, creates no hit.
REQ-027 Reset: rst during a pending load -> next cycle stall=0 and fwd_hit=0. With FWD_STATS_EN, both counters read 0.
